// File: rtl/npc_fetch_ctrl.sv
// npc_fetch_ctrl: fetch-side next-PC controller with imem req/ready handshake.
//
// Holds the fetch PC and issues one word-aligned fetch at a time to imem.
// Branch, jump and jr redirects come from the ID stage. Every redirect
// honours the MIPS single delay slot: the fetch that completes after the
// redirect (the delay slot) is always issued, and the target follows it.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   stall         IF freeze; only blocks the start of a new fetch
//   imem_req      fetch request (held until imem_ready)
//   imem_addr     fetch address (current PC)
//   imem_ready    imem accepts/returns the word this cycle
//   if_valid      one-cycle pulse after a completed fetch
//   if_pc         address of that completed fetch
//   id_valid      qualifies all id_* / br_* / j_* / jr_* inputs
//   id_pc         PC of the instruction in ID
//   br_en, br_taken, br_imm   conditional branch and its outcome / offset
//   j_en, j_index             j/jal and its index field
//   jr_en, jr_addr            jr/jalr and its register value
//   align_err     one-cycle pulse: jr target had non-zero low bits
//
// Optional feature (macro NPC_BRANCH_STATS_EN): saturating counters
//   stat_br, stat_taken, stat_redir of width STAT_W.

module npc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic              br_en,
  input  logic              br_taken,
  input  logic [15:0]       br_imm,
  input  logic              j_en,
  input  logic [25:0]       j_index,
  input  logic              jr_en,
  input  logic [31:0]       jr_addr,
`ifdef NPC_BRANCH_STATS_EN
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_redir,
`endif
  output logic              align_err
);

  typedef enum logic {StRun, StPend} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_tgt_q;
  logic        live_q;      // low until the first clock edge after reset
  logic        busy_q;      // a raised request has not yet completed
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic        align_err_q;

  logic        redir;
  logic        accept;
  logic        complete;
  logic [31:0] id_pc_plus4;
  logic [31:0] br_off;
  logic [31:0] tgt;

  assign redir       = id_valid & (jr_en | j_en | (br_en & br_taken));
  // Redirects arriving in StPend sit in a delay slot and are dropped.
  assign accept      = redir & (state_q == StRun);
  assign id_pc_plus4 = id_pc + 32'd4;
  assign br_off      = {{14{br_imm[15]}}, br_imm, 2'b00};

  always_comb begin
    tgt = id_pc_plus4 + br_off;
    if (jr_en) begin
      tgt = {jr_addr[31:2], 2'b00};
    end else if (j_en) begin
      tgt = {id_pc_plus4[31:28], j_index, 2'b00};
    end
  end

  // An outstanding request stays up regardless of stall; stall only gates a new one.
  assign imem_req  = live_q & (busy_q | ~stall);
  assign imem_addr = pc_q;
  assign complete  = imem_req & imem_ready;

  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign align_err = align_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      pend_tgt_q  <= 32'h0;
      live_q      <= 1'b0;
      busy_q      <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'h0;
      align_err_q <= 1'b0;
    end else begin
      live_q      <= 1'b1;
      busy_q      <= imem_req & ~imem_ready;
      if_valid_q  <= complete;
      align_err_q <= accept & jr_en & (jr_addr[1:0] != 2'b00);
      if (complete) begin
        if_pc_q <= pc_q;
      end
      case (state_q)
        StRun: begin
          if (complete) begin
            // A redirect seen together with a completion means that fetch was the delay slot.
            pc_q <= accept ? tgt : pc_q + 32'd4;
          end else if (accept) begin
            pend_tgt_q <= tgt;
            state_q    <= StPend;
          end
        end
        StPend: begin
          if (complete) begin
            pc_q    <= pend_tgt_q;
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef NPC_BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_br_q, stat_taken_q, stat_redir_q;
  logic [STAT_W-1:0] stat_one;

  assign stat_one = {{(STAT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q    <= '0;
      stat_taken_q <= '0;
      stat_redir_q <= '0;
    end else begin
      if (id_valid && br_en && stat_br_q != '1) begin
        stat_br_q <= stat_br_q + stat_one;
      end
      if (id_valid && br_en && br_taken && stat_taken_q != '1) begin
        stat_taken_q <= stat_taken_q + stat_one;
      end
      if (accept && stat_redir_q != '1) begin
        stat_redir_q <= stat_redir_q + stat_one;
      end
    end
  end

  assign stat_br    = stat_br_q;
  assign stat_taken = stat_taken_q;
  assign stat_redir = stat_redir_q;
`endif

endmodule
